// File: rtl/conv_out_stage.sv
// conv_out_stage: keeps full-window positions of the partial-sum stream, then adds bias,
// rounds, optionally applies ReLU and saturates into a valid-qualified output stream.
module conv_out_stage #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int KERNEL_WIDTH = 5,
    parameter int OUT_WIDTH    = 16,
    parameter int FRAC_SHIFT   = 8,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [39:0]          psum_in,
    input  logic                        psum_valid,
    input  logic                        sof,
    input  logic signed [15:0]          bias,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic                        frame_done
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] EDGE = CW'(KERNEL_WIDTH - 1);
    localparam logic signed [41:0] HALF = 42'sd1 <<< (FRAC_SHIFT - 1);
    localparam logic signed [41:0] MAXV = (42'sd1 <<< (OUT_WIDTH - 1)) - 42'sd1;
    localparam logic signed [41:0] MINV = -(42'sd1 <<< (OUT_WIDTH - 1));

    logic [CW-1:0] col_q, col_d, row_q, row_d, pos_col, pos_row;
    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic signed [40:0] s1_sum_q, s1_sum_d;
    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic signed [41:0] rnd, shr, rel;

    always_comb begin
        // sof forces the current word to (0,0); the counters then step from there
        pos_col = sof ? '0 : col_q;
        pos_row = sof ? '0 : row_q;
        col_d = !psum_valid ? col_q : pos_col == LAST ? '0 : pos_col + 1'b1;
        row_d = !psum_valid ? row_q : pos_col != LAST ? pos_row : pos_row == LAST ? '0 : pos_row + 1'b1;
        s1_valid_d = psum_valid && pos_row >= EDGE && pos_col >= EDGE;
        s1_last_d = s1_valid_d && pos_row == LAST && pos_col == LAST;
        s1_sum_d = 41'(psum_in) + 41'(bias);
        rnd = 42'(s1_sum_q) + HALF;
        shr = rnd >>> FRAC_SHIFT;
        rel = (RELU_EN && shr < 0) ? '0 : shr;
        out_data_d = !s1_valid_q ? out_data_q
                   : rel > MAXV ? MAXV[OUT_WIDTH-1:0]
                   : rel < MINV ? MINV[OUT_WIDTH-1:0]
                   : rel[OUT_WIDTH-1:0];
        out_valid_d = s1_valid_q;
        frame_done_d = s1_last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sum_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_sum_q     <= s1_sum_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_out_stage.sv
// tb_conv_out_stage: drives ReLU-on and ReLU-off instances with one stream and checks
// every cycle against a position/arithmetic model plus directed frame-level expectations.
module tb_conv_out_stage;
    logic clk = 1'b0;
    logic reset;
    logic signed [39:0] psum_in;
    logic psum_valid, sof;
    logic signed [15:0] bias;
    logic signed [15:0] o1, o0;
    logic v1, v0, d1, d0;

    int checks = 0, errs = 0;
    int mc = 0, mr = 0;
    bit pv = 0, pl = 0;
    longint pd1 = 0, pd0 = 0, ed1 = 0, ed0 = 0;
    int n_out = 0, n_done = 0, lbase = 0;
    longint last_done = 0;
    logic signed [15:0] log1 [576];
    logic signed [15:0] log0 [576];
    logic signed [15:0] ref1 [576];

    conv_out_stage #(.RELU_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .psum_in(psum_in), .psum_valid(psum_valid), .sof(sof),
        .bias(bias), .out_data(o1), .out_valid(v1), .frame_done(d1));
    conv_out_stage #(.RELU_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .psum_in(psum_in), .psum_valid(psum_valid), .sof(sof),
        .bias(bias), .out_data(o0), .out_valid(v0), .frame_done(d0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint mdl(input longint p, input longint b, input bit relu);
        longint r;
        r = (p + b + 128) >>> 8;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic logic signed [39:0] rnd40();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return ($urandom_range(0, 3) == 0) ? x[39:0] : 40'($signed(x[23:0]));
    endfunction

    task automatic clear_model();
        pv = 0; pl = 0; ed1 = 0; ed0 = 0; mc = 0; mr = 0;
    endtask

    task automatic cyc(input bit v, input bit s, input logic signed [39:0] p, input logic signed [15:0] b);
        bit kp, lst;
        int idx;
        psum_valid = v; sof = s; psum_in = p; bias = b;
        kp = 0; lst = 0;
        if (v) begin
            if (s) begin mc = 0; mr = 0; end
            kp = mr >= 4 && mc >= 4;
            lst = mr == 27 && mc == 27;
            mc++;
            if (mc == 28) begin mc = 0; mr = (mr + 1) % 28; end
        end
        @(posedge clk); #1;
        if (pv) begin ed1 = pd1; ed0 = pd0; end
        chk("valid_relu", v1, pv);
        chk("valid_norelu", v0, pv);
        chk("done_relu", d1, pl);
        chk("done_norelu", d0, pl);
        chk("data_relu", o1, ed1);
        chk("data_norelu", o0, ed0);
        if (v1) begin
            idx = n_out - lbase;
            if (idx >= 0 && idx < 576) begin log1[idx] = o1; log0[idx] = o0; end
            n_out++;
        end
        if (d1) begin n_done++; last_done = o1; end
        pv = kp; pl = lst;
        pd1 = mdl(longint'(p), longint'(b), 1'b1);
        pd0 = mdl(longint'(p), longint'(b), 1'b0);
    endtask

    // mode 0: ramp 256*index, bias 0; mode 1: random; mode 2: random with directed kept words
    task automatic run_frame(input int mode, input bit stall, input bit with_sof, input int n);
        logic signed [39:0] p;
        logic signed [15:0] b;
        for (int i = 0; i < n; i++) begin
            p = mode == 0 ? 40'(256 * i) : rnd40();
            b = mode == 0 ? 16'sd0 : 16'($urandom());
            if (mode == 2) begin
                case (i)
                    116: begin p = 40'sd383; b = 16'sd0; end
                    117: begin p = 40'sd384; b = 16'sd0; end
                    118: begin p = -40'sd1000; b = 16'sd0; end
                    119: begin p = 40'sh7F_FFFF_FFFF; b = 16'sd32767; end
                    120: begin p = 40'sh80_0000_0000; b = -16'sd32768; end
                    default: ;
                endcase
            end
            cyc(1'b1, with_sof && i == 0, p, b);
            if (stall) cyc(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic flush();
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int so, sd;
        reset = 1'b1; psum_valid = 0; sof = 0; psum_in = '0; bias = '0;
        clear_model();
        #2;
        chk("rst_valid", v1, 0);
        chk("rst_done", d1, 0);
        chk("rst_data", o1, 0);
        repeat (3) cyc(1'b0, 1'b0, '0, '0);
        reset = 1'b0;

        lbase = n_out; so = n_out; sd = n_done;
        run_frame(0, 0, 1, 784);
        flush();
        chk("ramp_count", n_out - so, 576);
        chk("ramp_done", n_done - sd, 1);
        chk("ramp_first", log1[0], 116);
        chk("ramp_last", last_done, 783);
        for (int i = 0; i < 576; i++) ref1[i] = log1[i];

        lbase = n_out; so = n_out;
        run_frame(2, 0, 1, 784);
        flush();
        chk("dir_count", n_out - so, 576);
        chk("round_383", log1[0], 1);
        chk("round_384", log1[1], 2);
        chk("relu_neg", log1[2], 0);
        chk("norelu_neg", log0[2], -4);
        chk("sat_pos", log1[3], 32767);
        chk("sat_pos_norelu", log0[3], 32767);
        chk("sat_neg_norelu", log0[4], -32768);
        chk("sat_neg_relu", log1[4], 0);

        lbase = n_out; so = n_out; sd = n_done;
        run_frame(0, 1, 1, 784);
        flush();
        chk("stall_count", n_out - so, 576);
        chk("stall_done", n_done - sd, 1);
        for (int i = 0; i < 576; i++) chk("stall_value", log1[i], ref1[i]);

        run_frame(1, 0, 1, 300);
        so = n_out; sd = n_done;
        run_frame(1, 0, 1, 784);
        run_frame(0, 0, 0, 784);
        flush();
        chk("resync_b2b_count", n_out - so, 1 + 2 * 576);
        chk("resync_b2b_done", n_done - sd, 2);

        run_frame(1, 0, 1, 400);
        chk("pre_rst_valid", v1, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid_relu", v1, 0);
        chk("async_valid_norelu", v0, 0);
        chk("async_done", d1, 0);
        chk("async_data_relu", o1, 0);
        chk("async_data_norelu", o0, 0);
        clear_model();
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        lbase = n_out; so = n_out; sd = n_done;
        run_frame(0, 0, 0, 784);
        flush();
        chk("post_rst_count", n_out - so, 576);
        chk("post_rst_done", n_done - sd, 1);
        chk("post_rst_last", last_done, 783);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/conv_out_stage.md
# conv_out_stage

Final stage of the streaming convolution pipeline. It consumes the 40-bit signed partial-sum stream leaving the last kernel row, one word per input pixel in raster order. It tracks the window position, keeps only positions where the full KERNEL_WIDTH x KERNEL_WIDTH window lies inside the image, and applies bias, optional ReLU, rounding right-shift and saturation. The result is a valid-qualified OUT_WIDTH-bit feature-map stream with an end-of-frame pulse.

## Interface
- IMAGE_WIDTH, 28, square input image side in pixels.
- KERNEL_WIDTH, 5, square kernel side; output map side is IMAGE_WIDTH-KERNEL_WIDTH+1 (24).
- OUT_WIDTH, 16, output sample width (signed).
- FRAC_SHIFT, 8, arithmetic right shift applied after bias (must be >= 1).
- RELU_EN, 1, 1 = clamp negatives to 0; 0 = pass signed.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- psum_in  input  40  signed partial sum for the current input pixel.
- psum_valid  input  1  psum_in is valid this cycle; position counters advance only on valid.
- sof  input  1  start of frame; when high with psum_valid, this word is position (0,0).
- bias  input  16  signed bias, same scale as psum_in; sampled with each valid word.
- out_data  output  OUT_WIDTH  signed result.
- out_valid  output  1  out_data valid (single-cycle per sample).
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- Position counters col, row each run 0..IMAGE_WIDTH-1. On valid: col increments, and wraps to 0 after IMAGE_WIDTH-1 with row+1. row wraps to 0 after the final pixel (IMAGE_WIDTH-1, IMAGE_WIDTH-1).
- sof with psum_valid: the word is treated as (0,0) and the counters load (0,1) for the next word. This takes priority over normal increment and resynchronises mid-frame; words already in the pipeline still drain.
- sof without psum_valid is ignored.
- A word is kept iff row >= KERNEL_WIDTH-1 and col >= KERNEL_WIDTH-1. Other words are discarded with no output.
- Stage 1 (kept words): sum = sext41(psum_in) + sext41(bias). 41-bit, no overflow possible.
- Stage 2:
  - r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. Round half up, computed at 42 bits.
  - If RELU_EN and r < 0, then r = 0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register into out_data.
- frame_done is asserted with the output from position (IMAGE_WIDTH-1, IMAGE_WIDTH-1).
- No backpressure: downstream must accept one sample per cycle.

## Timing
- Reset values: out_data=0, out_valid=0, frame_done=0, col=0, row=0, pipeline valid bits cleared. Reset mid-frame discards in-flight words; the next valid word is (0,0).
- Latency is 2 cycles: a kept word presented with psum_valid at edge N appears on out_data/out_valid after edge N+2.
- Throughput is 1 word/cycle. Gaps in psum_valid insert matching gaps in out_valid; pipeline stages advance every cycle regardless of valid.
- out_data holds its last value while out_valid=0.
- Per frame: exactly (IMAGE_WIDTH-KERNEL_WIDTH+1)^2 = 576 out_valid pulses and one frame_done.
- Back-to-back frames with no idle cycle are supported. Word (0,0) of frame k+1 may arrive the cycle after the last word of frame k, with or without sof.

## Test plan
- Reset then 784 valid words, psum_in = 256·(row·28+col), bias=0, RELU_EN=1:
  - first out_valid appears 2 cycles after word (4,4), with out_data=116.
  - 576 outputs total.
  - frame_done with the final output out_data=783.
- Rounding/ReLU: kept word psum_in=383, bias=0 -> 1 (383+128=511>>8). psum_in=384 -> 2. psum_in=-1000 with RELU_EN=1 -> 0. psum_in=-1000 with RELU_EN=0 -> -4.
- Saturation:
  - psum_in=2^39-1, bias=32767 -> 32767.
  - RELU_EN=0, psum_in=-2^39, bias=-32768 -> -32768.
- Stall: psum_valid low every other cycle for a whole frame -> same 576 values as the gapless run, each out_valid exactly 2 cycles after its input word; frame_done once.
- Resync: sof at input word 300 of a frame -> counters restart and that word is (0,0). The next 784 words produce 576 outputs and one frame_done; outputs emitted before the resync are unaffected.
- Async reset asserted mid-frame between edges -> out_valid and frame_done drop immediately and out_data=0. After release, a full frame yields 576 outputs.
